// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//   Multi-cycle magnitude comparator for WIDTH-bit operands. Scans DIGIT bits
//   per cycle starting from the most significant chunk and stops on the first
//   chunk that differs. Result code: 01 greater, 10 equal, 11 less, 00 none.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      compare request, sampled only while idle
//   A      in   WIDTH  operand A, captured on an accepted start
//   B      in   WIDTH  operand B, captured on an accepted start
//   sgn    in   1      (SIGNED_CMP_EN only) 1 = two's complement compare
//   busy   out  1      high while scanning and in the done cycle
//   done   out  1      one-cycle pulse; flag is valid in this cycle
//   flag   out  2      result code, held until the next result
//
// Configuration
//   SIGNED_CMP_EN  when defined, adds the sgn port for signed compares.

module serial_magnitude_comparator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SIGNED_CMP_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic [1:0]       flag
);

  localparam int unsigned DIG_SAFE = (DIGIT < 1) ? 1 : DIGIT;
  localparam int unsigned N        = WIDTH / DIG_SAFE;
  localparam int unsigned IDXW     = (N > 1) ? $clog2(N) : 1;

  // Reject operand/chunk geometries that cannot be scanned evenly.
  generate
    if (DIGIT < 1 || (WIDTH % DIG_SAFE) != 0) begin : g_bad_geometry
      $error("serial_magnitude_comparator: WIDTH must be a multiple of DIGIT and DIGIT >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             busy_d, done_d;
  logic [1:0]       flag_d;

  logic [DIGIT-1:0] chunk_a, chunk_b;
  logic [WIDTH-1:0] cap_a, cap_b;

  // Current chunk of each operand, selected by the chunk counter.
  assign chunk_a = DIGIT'(opa_q >> (DIGIT * 32'(idx_q)));
  assign chunk_b = DIGIT'(opb_q >> (DIGIT * 32'(idx_q)));

  // Signed operands become offset binary by flipping the MSB, so the unsigned
  // scan orders them correctly without any change to the datapath.
  always_comb begin
    cap_a = A;
    cap_b = B;
`ifdef SIGNED_CMP_EN
    cap_a[WIDTH-1] = A[WIDTH-1] ^ sgn;
    cap_b[WIDTH-1] = B[WIDTH-1] ^ sgn;
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      flag    <= 2'b00;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      idx_q   <= idx_d;
      busy    <= busy_d;
      done    <= done_d;
      flag    <= flag_d;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    idx_d   = idx_q;
    flag_d  = flag;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = cap_a;
          opb_d   = cap_b;
          idx_d   = IDXW'(N - 1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (chunk_a > chunk_b) begin
          flag_d  = 2'b01;
          state_d = DONE;
        end else if (chunk_a < chunk_b) begin
          flag_d  = 2'b11;
          state_d = DONE;
        end else if (idx_q == '0) begin
          flag_d  = 2'b10;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered copies of the decode of the next state.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator
//   Self-checking bench for serial_magnitude_comparator (WIDTH=16, DIGIT=4).
//   Expected results come from plain integer comparison of the operands and
//   the latency from the position of the most significant differing chunk.

module tb_serial_magnitude_comparator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        sgn;
  logic        busy;
  logic        done;
  logic [1:0]  flag;

  int unsigned nvec;
  int unsigned nerr;

  serial_magnitude_comparator #(
    .WIDTH(16),
    .DIGIT(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
`ifdef SIGNED_CMP_EN
    .sgn  (sgn),
`endif
    .busy (busy),
    .done (done),
    .flag (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: result code from integer ordering of the operands.
  function automatic logic [1:0] ref_flag(input logic [15:0] a, input logic [15:0] b, input logic s);
    int ia, ib;
    if (s) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    if (ia > ib) return 2'b01;
    if (ia < ib) return 2'b11;
    return 2'b10;
  endfunction

  // Reference: number of 4-bit chunks examined, MSB chunk first.
  function automatic int ref_chunks(input logic [15:0] a, input logic [15:0] b);
    int k;
    logic [15:0] diff;
    diff = a ^ b;
    k = 0;
    for (int c = 3; c >= 0; c--) begin
      k++;
      if (((diff >> (4 * c)) & 16'h000F) != 16'h0) break;
    end
    return k;
  endfunction

  // One compare; with disturb set, start is held and operands change while busy.
  task automatic run_cmp(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input bit disturb, input string tag);
    logic [1:0] ef;
    int         ek;
    int         cnt;
    ef = ref_flag(a, b, s);
    ek = ref_chunks(a, b);
    A = a;
    B = b;
    sgn = s;
    start = 1'b1;
    @(posedge clk); #1;
    cnt = 1;
    if (disturb) begin
      A = 16'hFFFF;
      B = 16'h0000;
      sgn = ~s;
    end else begin
      start = 1'b0;
    end
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
      if (done !== 1'b1) check({tag, "_busy_scan"}, 32'(busy), 32'd1);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(cnt), 32'(ek + 1));
    check({tag, "_flag"}, 32'(flag), 32'(ef));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_fall"}, 32'(done), 32'd0);
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    check({tag, "_flag_hold"}, 32'(flag), 32'(ef));
    if (disturb) begin
      repeat (4) begin
        @(posedge clk); #1;
        check({tag, "_no_extra_done"}, 32'(done), 32'd0);
        check({tag, "_idle_flag"}, 32'(flag), 32'(ef));
      end
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rs;
    int          cnt;
    nvec  = 0;
    nerr  = 0;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    sgn   = 1'b0;

    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_flag", 32'(flag), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases.
    run_cmp(16'h1234, 16'h1234, 1'b0, 1'b0, "t1_equal");
    run_cmp(16'h9000, 16'h1FFF, 1'b0, 1'b0, "t2_early_gt");
    run_cmp(16'h1233, 16'h1234, 1'b0, 1'b0, "t3_less");
    run_cmp(16'h1233, 16'h1234, 1'b0, 1'b1, "t4_ignore_busy");

    // Reset in the middle of a compare.
    A = 16'h1234;
    B = 16'h1234;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_flag", 32'(flag), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check("t5_no_done", 32'(done), 32'd0);
    end
    run_cmp(16'h0001, 16'h0002, 1'b0, 1'b0, "t5_after_rst");

    // Start held high: next compare accepted on the first idle cycle.
    A = 16'h4321;
    B = 16'h4320;
    start = 1'b1;
    cnt = 0;
    @(posedge clk); #1;
    while (done !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("held_done", 32'(done), 32'd1);
    check("held_flag", 32'(flag), 32'h1);
    @(posedge clk); #1;
    check("held_idle_gap", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("held_reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    cnt = 0;
    while (done !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("held_second_done", 32'(done), 32'd1);
    @(posedge clk); #1;

`ifdef SIGNED_CMP_EN
    run_cmp(16'hFFFF, 16'h0001, 1'b1, 1'b0, "t6_signed");
    run_cmp(16'hFFFF, 16'h0001, 1'b0, 1'b0, "t6_unsigned");
`endif

    // Random operands.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
`ifdef SIGNED_CMP_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_cmp(ra, rb, rs, 1'b0, "rnd");
    end

    // Random operands sharing high chunks, to exercise late exits.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      if ((i % 4) == 0) rb = ra;
      else rb = ra ^ (16'h0001 << $urandom_range(15, 0));
`ifdef SIGNED_CMP_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_cmp(ra, rb, rs, 1'b0, "rnd_near");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
